fa_n_bit: RTL and testbench



---
 rtl/fa_n_bit_pkg.sv | 16 +
 rtl/full_adder_cell.sv | 13 +
 rtl/fa_n_bit.sv | 59 +++++
 tb/tb_fa_n_bit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fa_n_bit_pkg.sv
// Shared constants and the reference-sum helper for the fa_n_bit ripple-carry adder.
package fa_n_bit_pkg;

  localparam int FA_N_BIT_DEFAULT_N = 2;
  localparam int FA_N_BIT_REF_W     = 32;

  // Exact (W+1)-bit sum for operands up to FA_N_BIT_REF_W bits wide.
  function automatic logic [FA_N_BIT_REF_W:0] fa_ref_sum(
    input logic [FA_N_BIT_REF_W-1:0] a,
    input logic [FA_N_BIT_REF_W-1:0] b,
    input logic                      rin
  );
    return {1'b0, a} + {1'b0, b} + (FA_N_BIT_REF_W+1)'(rin);
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder; one link of the fa_n_bit carry chain.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/fa_n_bit.sv
// N-bit ripple-carry adder with registered sum/carry and a valid qualifier.
// Define FA_N_BIT_OVF_EN to add the registered signed-overflow output ovf.
module fa_n_bit
  import fa_n_bit_pkg::*;
#(
  parameter int N = FA_N_BIT_DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
`ifdef FA_N_BIT_OVF_EN
  output logic         ovf,
`endif
  output logic         rout,
  output logic [N-1:0] z,
  input  logic         rin,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         in_valid,
  output logic         out_valid
);

  logic [N:0]   c;
  logic [N-1:0] s;

  assign c[0] = rin;

  for (genvar i = 0; i < N; i++) begin : g_cell
    full_adder_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      z         <= '0;
      rout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        z    <= s;
        rout <= c[N];
      end
    end
  end

`ifdef FA_N_BIT_OVF_EN
  // Carry into and out of the sign bit differ exactly on two's-complement overflow.
  always_ff @(posedge clk) begin
    if (rst)           ovf <= 1'b0;
    else if (in_valid) ovf <= c[N] ^ c[N-1];
  end
`endif

endmodule

// File: tb/tb_fa_n_bit.sv
// Self-checking bench for fa_n_bit: N=2 and N=8 instances against an arithmetic model.
module tb_fa_n_bit;
  import fa_n_bit_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // N=2 instance
  logic       rst2, rin2, v2, rout2, ov2;
  logic [1:0] a2, b2, z2;
  // N=8 instance
  logic       rst8, rin8, v8, rout8, ov8;
  logic [7:0] a8, b8, z8;
`ifdef FA_N_BIT_OVF_EN
  logic       ovf2, ovf8;
`endif

  fa_n_bit #(.N(FA_N_BIT_DEFAULT_N)) dut2 (
    .clk(clk), .rst(rst2),
`ifdef FA_N_BIT_OVF_EN
    .ovf(ovf2),
`endif
    .rout(rout2), .z(z2), .rin(rin2), .a(a2), .b(b2),
    .in_valid(v2), .out_valid(ov2)
  );

  fa_n_bit #(.N(8)) dut8 (
    .clk(clk), .rst(rst8),
`ifdef FA_N_BIT_OVF_EN
    .ovf(ovf8),
`endif
    .rout(rout8), .z(z8), .rin(rin8), .a(a8), .b(b8),
    .in_valid(v8), .out_valid(ov8)
  );

  // Model state of the registered outputs
  logic [1:0] m_z2;  logic m_r2, m_v2, m_o2;
  logic [7:0] m_z8;  logic m_r8, m_v8, m_o8;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic       rin;
    logic [2:0] sum;
  } vec2_t;
  vec2_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Signed overflow from value ranges, not from carries
  function automatic logic sovf(input int sa, input int sb, input int c, input int w);
    int r;
    r = sa + sb + c;
    return (r > (2 ** (w-1)) - 1) || (r < -(2 ** (w-1)));
  endfunction

  task automatic step2(input string name, input logic r, input logic v,
                       input logic [1:0] a, input logic [1:0] b, input logic c);
    int sa, sb, sum;
    rst2 = r; v2 = v; a2 = a; b2 = b; rin2 = c;
    @(posedge clk); #1;
    sum = int'(a) + int'(b) + int'(c);
    sa = a[1] ? int'(a) - 4 : int'(a);
    sb = b[1] ? int'(b) - 4 : int'(b);
    if (r) begin
      m_z2 = 0; m_r2 = 0; m_v2 = 0; m_o2 = 0;
    end else begin
      m_v2 = v;
      if (v) begin
        m_z2 = 2'(sum % 4); m_r2 = (sum >= 4); m_o2 = sovf(sa, sb, int'(c), 2);
      end
    end
    check({name, ".z"},    32'(z2),    32'(m_z2));
    check({name, ".rout"}, 32'(rout2), 32'(m_r2));
    check({name, ".vld"},  32'(ov2),   32'(m_v2));
`ifdef FA_N_BIT_OVF_EN
    check({name, ".ovf"},  32'(ovf2),  32'(m_o2));
`endif
  endtask

  task automatic step8(input string name, input logic r, input logic v,
                       input logic [7:0] a, input logic [7:0] b, input logic c);
    int sa, sb, sum;
    rst8 = r; v8 = v; a8 = a; b8 = b; rin8 = c;
    @(posedge clk); #1;
    sum = int'(a) + int'(b) + int'(c);
    sa = a[7] ? int'(a) - 256 : int'(a);
    sb = b[7] ? int'(b) - 256 : int'(b);
    if (r) begin
      m_z8 = 0; m_r8 = 0; m_v8 = 0; m_o8 = 0;
    end else begin
      m_v8 = v;
      if (v) begin
        m_z8 = 8'(sum % 256); m_r8 = (sum >= 256); m_o8 = sovf(sa, sb, int'(c), 8);
      end
    end
    check({name, ".z"},    32'(z8),    32'(m_z8));
    check({name, ".rout"}, 32'(rout8), 32'(m_r8));
    check({name, ".vld"},  32'(ov8),   32'(m_v8));
`ifdef FA_N_BIT_OVF_EN
    check({name, ".ovf"},  32'(ovf8),  32'(m_o8));
`endif
  endtask

  initial begin
    logic [4:0] idx;
    vec2_t e;
    rst2 = 1; v2 = 0; a2 = 0; b2 = 0; rin2 = 0;
    rst8 = 1; v8 = 0; a8 = 0; b8 = 0; rin8 = 0;

    // Reset dominates in_valid
    for (int i = 0; i < 2; i++) step2("rst2", 1, 1, 2'd3, 2'd3, 1);
    for (int i = 0; i < 2; i++) step8("rst8", 1, 1, 8'd255, 8'd255, 1);
    rst8 = 0;

    // Exhaustive N=2 table with known answers first
    e.a = 2'b01; e.b = 2'b10; e.rin = 1; e.sum = 3'b100; tbl.push_back(e);
    e.a = 2'b11; e.b = 2'b11; e.rin = 1; e.sum = 3'b111; tbl.push_back(e);
    e.a = 2'b00; e.b = 2'b00; e.rin = 0; e.sum = 3'b000; tbl.push_back(e);
    for (int i = 0; i < 32; i++) begin
      idx = 5'(i);
      e.a = idx[4:3]; e.b = idx[2:1]; e.rin = idx[0];
      e.sum = 3'(int'(e.a) + int'(e.b) + int'(e.rin));
      tbl.push_back(e);
    end
    foreach (tbl[k]) begin
      rst2 = 0; v2 = 1; a2 = tbl[k].a; b2 = tbl[k].b; rin2 = tbl[k].rin;
      @(posedge clk); #1;
      check("tbl.sum", 32'({rout2, z2}), 32'(tbl[k].sum));
      check("tbl.vld", 32'(ov2), 32'd1);
    end
    m_z2 = tbl[tbl.size()-1].sum[1:0]; m_r2 = tbl[tbl.size()-1].sum[2];
    m_v2 = 1; m_o2 = 0;  // last entry 3+3+1 = -1 signed, no overflow

    // Hold
    step2("hold.load", 0, 1, 2'd2, 2'd1, 0);
    step2("hold.idle", 0, 0, 2'd3, 2'd3, 0);
    step2("hold.idle2", 0, 0, 2'd1, 2'd2, 1);

    // Wide-width directed cases
    step8("w.255+1", 0, 1, 8'd255, 8'd1, 0);
    check("w.255+1.z0", 32'(z8), 32'd0);
    step8("w.100+27+1", 0, 1, 8'd100, 8'd27, 1);
    check("w.100+27+1.z", 32'(z8), 32'd128);
    step8("w.ones", 0, 1, 8'd255, 8'd255, 1);
    step8("w.zero", 0, 1, 8'd0, 8'd0, 0);
    step8("ov.127+1", 0, 1, 8'd127, 8'd1, 0);
    step8("ov.128+128", 0, 1, 8'd128, 8'd128, 0);
    step8("ov.5-6", 0, 1, 8'd5, 8'd250, 0);
`ifdef FA_N_BIT_OVF_EN
    step8("ov.hold", 0, 0, 8'd0, 8'd0, 0);
`endif

    // Random stream with valid gaps
    for (int i = 0; i < 300; i++) begin
      step8("rnd8", 0, 1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 1'($urandom));
      step2("rnd2", 0, 1'($urandom), 2'($urandom), 2'($urandom), 1'($urandom));
    end

    // Mid-stream reset
    step8("mid.a", 0, 1, 8'd200, 8'd100, 1);
    step8("mid.rst", 1, 1, 8'd17, 8'd34, 0);
    step8("mid.after", 0, 1, 8'd17, 8'd34, 0);
    check("mid.after.z", 32'(z8), 32'd51);
    step2("mid2.a", 0, 1, 2'd3, 2'd2, 0);
    step2("mid2.rst", 1, 1, 2'd1, 2'd1, 1);
    step2("mid2.after", 0, 1, 2'd1, 2'd1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
